// File: rtl/priority_ack_controller.sv
// Priority interrupt controller with a two-strobe acknowledge handshake, nested in-service tracking and optional rotation.
// Latency: a request sets irr one edge after irq rises, int_out follows one edge later, and data_valid pulses one edge after the second inta.
// Backpressure: none. inta is ignored in VEC, and edge requests that arrive mid-sequence stay in irr until the FSM is back in IDLE.
// Ports: clk/reset (sync, active-high); irq, inta, eoi, eoi_specific, eoi_level, auto_eoi, rotate_mode, vector_base in;
//        int_out, data_out {vector_base,id}, data_valid, irr, isr out.
module priority_ack_controller #(
    parameter bit EDGE_TRIGGERED = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] irq,
    input  logic       inta,
    input  logic       eoi,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    input  logic       auto_eoi,
    input  logic       rotate_mode,
    input  logic [4:0] vector_base,
    output logic       int_out,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic [7:0] irr,
    output logic [7:0] isr
);

    typedef enum logic [1:0] {IDLE, ACK1, VEC} state_t;

    state_t     state_q, state_d;
    logic [7:0] irr_q, irr_d, isr_q, isr_d, irq_q;
    logic [2:0] lp_q, lp_d, id_q, id_d;
    logic       spur_q, spur_d;
    logic       int_out_q, int_out_d;
    logic       dv_q, dv_d;
    logic [7:0] dout_q, dout_d;
    logic [7:0] irr_clr;

    logic [2:0] lp_eff;
    logic       win_vld, top_vld, eoi_hit;
    logic [2:0] win_id, top_id, eoi_id;

    // Fixed mode behaves as if IR7 was the last one serviced, so IR0 ranks first.
    assign lp_eff = rotate_mode ? lp_q : 3'd7;

    // Walk the priority ring from lp+1. The first isr bit met blocks every lower
    // request (fully nested), and it is also the target of a non-specific EOI.
    always_comb begin
        logic [2:0] idx;
        logic       blocked;
        win_vld = 1'b0;
        win_id  = 3'd0;
        top_vld = 1'b0;
        top_id  = 3'd0;
        blocked = 1'b0;
        idx     = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            idx = lp_eff + 3'(k);
            if (!blocked) begin
                if (isr_q[idx]) begin
                    blocked = 1'b1;
                end else if (irr_q[idx]) begin
                    win_vld = 1'b1;
                    win_id  = idx;
                    blocked = 1'b1;
                end
            end
            if (!top_vld && isr_q[idx]) begin
                top_vld = 1'b1;
                top_id  = idx;
            end
        end
    end

    // An EOI that targets an idle bit, or arrives with isr empty, does nothing.
    always_comb begin
        if (eoi_specific) begin
            eoi_id  = eoi_level;
            eoi_hit = eoi && isr_q[eoi_level];
        end else begin
            eoi_id  = top_id;
            eoi_hit = eoi && top_vld;
        end
    end

    always_comb begin
        state_d   = state_q;
        isr_d     = isr_q;
        lp_d      = lp_q;
        id_d      = id_q;
        spur_d    = spur_q;
        int_out_d = 1'b0;
        dv_d      = 1'b0;
        dout_d    = dout_q;
        irr_clr   = 8'h00;

        // The EOI is judged against the current isr. An acknowledge in the same
        // cycle only sets a bit above every in-service level, so the two updates never collide.
        if (eoi_hit) begin
            isr_d[eoi_id] = 1'b0;
            if (rotate_mode) lp_d = eoi_id;
        end

        case (state_q)
            IDLE: begin
                if (inta) begin
                    state_d = ACK1;
                    id_d    = win_vld ? win_id : 3'd7;
                    spur_d  = !win_vld;
                    if (win_vld) begin
                        isr_d[win_id]   = 1'b1;
                        irr_clr[win_id] = 1'b1;
                    end
                end else begin
                    int_out_d = win_vld;
                end
            end
            ACK1: begin
                if (inta) begin
                    state_d = VEC;
                    dv_d    = 1'b1;
                    dout_d  = {vector_base, id_q};
                    if (auto_eoi && !spur_q) begin
                        isr_d[id_q] = 1'b0;
                        if (rotate_mode) lp_d = id_q;
                    end
                end
            end
            VEC:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (EDGE_TRIGGERED) irr_d = (irr_q & ~irr_clr) | (irq & ~irq_q);
        else                irr_d = irq;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            irr_q     <= 8'h00;
            isr_q     <= 8'h00;
            irq_q     <= 8'h00;
            lp_q      <= 3'd7;
            id_q      <= 3'd0;
            spur_q    <= 1'b0;
            int_out_q <= 1'b0;
            dv_q      <= 1'b0;
            dout_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            irr_q     <= irr_d;
            isr_q     <= isr_d;
            irq_q     <= irq;
            lp_q      <= lp_d;
            id_q      <= id_d;
            spur_q    <= spur_d;
            int_out_q <= int_out_d;
            dv_q      <= dv_d;
            dout_q    <= dout_d;
        end
    end

    assign int_out    = int_out_q;
    assign data_out   = dout_q;
    assign data_valid = dv_q;
    assign irr        = irr_q;
    assign isr        = isr_q;

endmodule

// File: tb/tb_priority_ack_controller.sv
module tb_priority_ack_controller;

    logic       clk = 1'b0;
    logic       reset, inta, eoi, eoi_specific, auto_eoi, rotate_mode;
    logic [7:0] irq;
    logic [2:0] eoi_level;
    logic [4:0] vector_base;

    logic       e_int_out, e_dv, l_int_out, l_dv;
    logic [7:0] e_dout, e_irr, e_isr, l_dout, l_irr, l_isr;

    always #5 clk = ~clk;

    priority_ack_controller #(.EDGE_TRIGGERED(1'b1)) dut (
        .clk(clk), .reset(reset), .irq(irq), .inta(inta), .eoi(eoi),
        .eoi_specific(eoi_specific), .eoi_level(eoi_level), .auto_eoi(auto_eoi),
        .rotate_mode(rotate_mode), .vector_base(vector_base),
        .int_out(e_int_out), .data_out(e_dout), .data_valid(e_dv), .irr(e_irr), .isr(e_isr)
    );

    priority_ack_controller #(.EDGE_TRIGGERED(1'b0)) dut_lvl (
        .clk(clk), .reset(reset), .irq(irq), .inta(inta), .eoi(eoi),
        .eoi_specific(eoi_specific), .eoi_level(eoi_level), .auto_eoi(auto_eoi),
        .rotate_mode(rotate_mode), .vector_base(vector_base),
        .int_out(l_int_out), .data_out(l_dout), .data_valid(l_dv), .irr(l_irr), .isr(l_isr)
    );

    int total = 0;
    int bad   = 0;

    // Reference state for the edge-mode instance.
    logic [7:0] m_irr, m_isr, m_irq;
    int         m_lp;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic m_reset();
        m_irr = 8'h00;
        m_isr = 8'h00;
        m_irq = 8'h00;
        m_lp  = 7;
    endtask

    // The ring starts just after the last-serviced level. An in-service level
    // stops the search, because only strictly higher requests may nest.
    function automatic int m_win();
        int l = rotate_mode ? m_lp : 7;
        for (int k = 1; k <= 8; k++) begin
            int i = (l + k) % 8;
            if (m_isr[i]) return -1;
            if (m_irr[i]) return i;
        end
        return -1;
    endfunction

    function automatic int m_top_isr();
        int l = rotate_mode ? m_lp : 7;
        for (int k = 1; k <= 8; k++) begin
            int i = (l + k) % 8;
            if (m_isr[i]) return i;
        end
        return -1;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_irr"}, e_irr, m_irr);
        chk({tag, "_isr"}, e_isr, m_isr);
        chk({tag, "_int"}, 8'(e_int_out), 8'(m_win() >= 0));
    endtask

    task automatic set_irq(input string tag, input logic [7:0] v);
        m_irr = m_irr | (v & ~m_irq);
        m_irq = v;
        irq   = v;
        cyc();
        cyc();
        check_idle(tag);
    endtask

    task automatic do_eoi(input string tag, input logic spec, input logic [2:0] lvl);
        int t;
        if (spec) begin
            if (m_isr[lvl]) begin
                m_isr[lvl] = 1'b0;
                if (rotate_mode) m_lp = int'(lvl);
            end
        end else begin
            t = m_top_isr();
            if (t >= 0) begin
                m_isr[t] = 1'b0;
                if (rotate_mode) m_lp = t;
            end
        end
        eoi = 1'b1; eoi_specific = spec; eoi_level = lvl;
        cyc();
        eoi = 1'b0;
        cyc();
        check_idle(tag);
    endtask

    // Full two-strobe acknowledge. with_eoi raises a non-specific EOI alongside
    // the first strobe; the model judges both against the state before the edge.
    task automatic do_ack(input string tag, input logic with_eoi, output logic [2:0] id);
        int w, t;
        w = m_win();
        t = m_top_isr();
        inta = 1'b1;
        eoi = with_eoi; eoi_specific = 1'b0;
        cyc();
        inta = 1'b0; eoi = 1'b0;
        if (with_eoi && t >= 0) begin
            m_isr[t] = 1'b0;
            if (rotate_mode) m_lp = t;
        end
        if (w >= 0) begin
            id = 3'(w);
            m_isr[id] = 1'b1;
            m_irr[id] = 1'b0;
        end else begin
            id = 3'd7;
        end
        chk({tag, "_a1int"}, 8'(e_int_out), 8'h00);
        chk({tag, "_a1isr"}, e_isr, m_isr);
        chk({tag, "_a1irr"}, e_irr, m_irr);
        chk({tag, "_a1dv"}, 8'(e_dv), 8'h00);
        cyc();
        inta = 1'b1;
        cyc();
        inta = 1'b0;
        if (auto_eoi && w >= 0) begin
            m_isr[id] = 1'b0;
            if (rotate_mode) m_lp = int'(id);
        end
        chk({tag, "_dv"}, 8'(e_dv), 8'h01);
        chk({tag, "_vec"}, e_dout, {vector_base, id});
        cyc();
        chk({tag, "_dv0"}, 8'(e_dv), 8'h00);
        cyc();
        check_idle(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] id;
        reset = 1'b1; inta = 1'b0; eoi = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0;
        auto_eoi = 1'b0; rotate_mode = 1'b0; irq = 8'h00; vector_base = 5'h01;
        m_reset();
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        chk("rst_irr", e_irr, 8'h00);
        chk("rst_isr", e_isr, 8'h00);
        chk("rst_int", 8'(e_int_out), 8'h00);
        chk("rst_dv", 8'(e_dv), 8'h00);
        chk("rst_dout", e_dout, 8'h00);

        // Single IR2 request in fixed mode.
        set_irq("ir2", 8'h04);
        chk("ir2_int", 8'(e_int_out), 8'h01);
        do_ack("ir2", 1'b0, id);
        chk("ir2_id", 8'(id), 8'h02);
        chk("ir2_isr", e_isr, 8'h04);
        chk("ir2_irr", e_irr, 8'h00);
        do_eoi("ir2_eoi", 1'b0, 3'd0);
        set_irq("ir2_off", 8'h00);

        // IR0 and IR7 together: IR7 waits for the EOI of IR0.
        set_irq("ir07", 8'h81);
        do_ack("ir0", 1'b0, id);
        chk("ir0_id", 8'(id), 8'h00);
        chk("ir0_isr", e_isr, 8'h01);
        chk("ir7_held", 8'(e_int_out), 8'h00);
        do_eoi("ir0_eoi", 1'b0, 3'd0);
        chk("ir7_int", 8'(e_int_out), 8'h01);
        do_ack("ir7", 1'b0, id);
        chk("ir7_id", 8'(id), 8'h07);
        do_eoi("ir7_eoi", 1'b0, 3'd0);
        set_irq("ir07_off", 8'h00);

        // Nesting, specific EOI, and an EOI landing on the first strobe.
        set_irq("nest2", 8'h04);
        do_ack("nest2", 1'b0, id);
        set_irq("nest1", 8'h06);
        do_ack("nest1", 1'b0, id);
        chk("nest1_id", 8'(id), 8'h01);
        chk("nest_isr", e_isr, 8'h06);
        do_eoi("spec2", 1'b1, 3'd2);
        chk("spec2_isr", e_isr, 8'h02);
        set_irq("coin0", 8'h07);
        do_ack("coin", 1'b1, id);
        chk("coin_id", 8'(id), 8'h00);
        chk("coin_isr", e_isr, 8'h01);
        do_eoi("coin_eoi", 1'b0, 3'd0);
        set_irq("coin_off", 8'h00);

        // Rotation with automatic EOI.
        rotate_mode = 1'b1; auto_eoi = 1'b1;
        set_irq("rot3", 8'h08);
        do_ack("rot3", 1'b0, id);
        chk("rot3_id", 8'(id), 8'h03);
        chk("rot3_isr", e_isr, 8'h00);
        set_irq("rot_off", 8'h00);
        set_irq("rot34", 8'h18);
        do_ack("rot4", 1'b0, id);
        chk("rot4_id", 8'(id), 8'h04);
        do_ack("rot3b", 1'b0, id);
        chk("rot3b_id", 8'(id), 8'h03);
        set_irq("rot34_off", 8'h00);

        // Reset while waiting for the second strobe.
        auto_eoi = 1'b0;
        set_irq("ra1", 8'h02);
        set_irq("ra1_off", 8'h00);
        inta = 1'b1;
        cyc();
        inta = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        m_reset();
        chk("ra_isr", e_isr, 8'h00);
        chk("ra_irr", e_irr, 8'h00);
        for (int i = 0; i < 3; i++) begin
            chk("ra_nodv", 8'(e_dv), 8'h00);
            cyc();
        end
        set_irq("ra_lp", 8'h11);
        do_ack("ra_lp", 1'b0, id);
        chk("ra_lp_id", 8'(id), 8'h00);
        do_eoi("ra_eoi", 1'b0, 3'd0);
        set_irq("ra_off", 8'h00);

        // Random operations against the model.
        for (int n = 0; n < 200; n++) begin
            rotate_mode = 1'($urandom_range(0, 1));
            auto_eoi    = 1'($urandom_range(0, 1));
            vector_base = 5'($urandom);
            case ($urandom_range(0, 3))
                0:       set_irq("rnd_irq", 8'($urandom));
                1, 2:    do_ack("rnd_ack", 1'($urandom_range(0, 3) == 0), id);
                default: do_eoi("rnd_eoi", 1'($urandom_range(0, 1)), 3'($urandom));
            endcase
        end

        // Level mode: the request vanishes before the acknowledge.
        irq = 8'h00; rotate_mode = 1'b0; auto_eoi = 1'b0; vector_base = 5'h15;
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        m_reset();
        irq = 8'h20;
        cyc();
        chk("lvl_irr", l_irr, 8'h20);
        cyc();
        chk("lvl_int", 8'(l_int_out), 8'h01);
        irq = 8'h00;
        cyc();
        chk("lvl_irr0", l_irr, 8'h00);
        inta = 1'b1;
        cyc();
        inta = 1'b0;
        chk("lvl_a1isr", l_isr, 8'h00);
        cyc();
        inta = 1'b1;
        cyc();
        inta = 1'b0;
        chk("lvl_dv", 8'(l_dv), 8'h01);
        chk("lvl_vec", l_dout, 8'hAF);
        chk("lvl_isr", l_isr, 8'h00);
        cyc();
        chk("lvl_dv0", 8'(l_dv), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/priority_ack_controller.md
PRIORITY_ACK_CONTROLLER -- requirements
Module: priority_ack_controller

Interface
REQ-001 SHALL have parameter EDGE_TRIGGERED, default 1, meaning 1 = IRR bit sets on irq rising edge, 0 = level-sensitive.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port irq  input  8  masked interrupt requests (mask applied upstream).
REQ-005 SHALL have port inta  input  1  one-cycle acknowledge strobe; two strobes form one acknowledge sequence.
REQ-006 SHALL have port eoi  input  1  one-cycle end-of-interrupt command strobe.
REQ-007 SHALL have port eoi_specific  input  1  1 = specific EOI using eoi_level; 0 = non-specific.
REQ-008 SHALL have port eoi_level  input  3  IR index for specific EOI.
REQ-009 SHALL have port auto_eoi  input  1  1 = clear ISR bit at the second inta strobe.
REQ-010 SHALL have port rotate_mode  input  1  1 = rotating priority; 0 = fixed, IR0 highest.
REQ-011 SHALL have port vector_base  input  5  upper five bits of the vector.
REQ-012 SHALL have port int_out  output  1  interrupt request to the CPU.
REQ-013 SHALL have port data_out  output  8  vector {vector_base, id}.
REQ-014 SHALL have port data_valid  output  1  one-cycle vector-valid strobe.
REQ-015 SHALL have ports irr and isr  output  8 each  request and in-service registers.

Function
REQ-016 SHALL hold lowest-priority index lp (3 bits); priority order is lp+1, lp+2, ... lp (mod 8), and fixed mode forces lp = 7.
REQ-017 SHALL, with EDGE_TRIGGERED=1, set irr[i] on the registered 0->1 transition of irq[i] and clear it only at the first inta strobe of its acknowledge.
REQ-018 SHALL, with EDGE_TRIGGERED=0, load irr from irq every cycle.
REQ-019 SHALL resolve the winner as the highest-priority irr bit strictly higher in priority than the highest-priority isr bit (fully nested), combinationally from the registered irr/isr/lp.
REQ-020 SHALL register int_out high one cycle after a winner exists in state IDLE.
REQ-021 SHALL implement states IDLE, ACK1 and VEC.
REQ-022 SHALL, on an inta strobe in IDLE, latch the winner id, set isr[id], clear irr[id] in edge mode, drop int_out next cycle, and go to ACK1.
REQ-023 SHALL, when no winner exists at the first inta strobe, latch id = 7 flagged spurious and leave isr/irr unchanged.
REQ-024 SHALL, on an inta strobe in ACK1, drive data_out = {vector_base, id} with data_valid = 1 for exactly the next cycle (state VEC), then return to IDLE.
REQ-025 SHALL, at the second strobe with auto_eoi=1 and non-spurious id, clear isr[id]; if rotate_mode=1, also set lp = id.
REQ-026 SHALL, on a non-specific EOI, clear the highest-priority set isr bit; if rotate_mode=1, set lp to that index.
REQ-027 SHALL, on a specific EOI, clear isr[eoi_level]; if rotate_mode=1, set lp = eoi_level.
REQ-028 SHALL ignore an EOI when the targeted isr bit or the whole isr is zero.
REQ-029 SHALL, when eoi coincides with the first inta strobe, evaluate the EOI against the pre-acknowledge isr and apply both updates in the same cycle.
REQ-030 SHALL ignore inta strobes while in VEC.
REQ-031 SHALL keep new edge requests arriving during ACK1/VEC latched in irr, and re-evaluate them in IDLE.

Reset
REQ-032 SHALL, while reset is high at a clock edge, clear irr, isr, int_out, data_out, data_valid and the edge-detect register, set lp = 7 and state = IDLE.
REQ-033 SHALL, on reset asserted mid-sequence (ACK1/VEC), abort the sequence with no data_valid pulse.

Verification
REQ-034 SHALL verify: irq = 8'h04 rising, fixed, vector_base = 5'h01 -> int_out = 1; two inta -> data_out = 8'h0A, isr = 8'h04, irr = 0.
REQ-035 SHALL verify: irq 8'h81 simultaneous, fixed -> IR0 served first; isr = 8'h01; IR7 is not presented until a non-specific EOI, then data_out low bits = 7.
REQ-036 SHALL verify: rotate_mode = 1, auto_eoi = 1, IR3 then IR3 and IR4 pending -> after the first ack lp = 3, the next vector id = 4.
REQ-037 SHALL verify: level mode, irq[5] drops between int_out and the first inta -> spurious id 7, isr stays 0.
REQ-038 SHALL verify: isr = 8'h04, IR1 request -> IR1 nests (isr = 8'h06); a specific EOI with eoi_level = 2 -> isr = 8'h02.
REQ-039 SHALL verify: reset asserted in ACK1 -> next cycle state IDLE, isr = 0, lp = 7, no data_valid pulse.
